mouse_cell_tracker: RTL and testbench

MOUSE_CELL_TRACKER -- requirements
Module: mouse_cell_tracker

---
 rtl/mouse_cell_tracker_if.sv | 27 ++
 rtl/mouse_cell_tracker.sv | 188 ++++++++++++++++++
 tb/tb_mouse_cell_tracker.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mouse_cell_tracker_if.sv
// PS/2 byte input and cursor/button outputs of the mouse cell tracker.
// master drives bytes and reads state; slave is the tracker itself.
interface mouse_cell_tracker_if #(
  parameter int UPPER_BITS = 7
);
  logic [7:0]            iByte;
  logic                  iByteValid;
  logic [UPPER_BITS-1:0] oX_cell;
  logic [UPPER_BITS-1:0] oY_cell;
  logic                  oLeft;
  logic                  oRight;
  logic                  oBusy;
  logic                  oPacket;
  logic                  oOverrun;

  modport master (
    output iByte, iByteValid,
    input  oX_cell, oY_cell, oLeft, oRight,
    input  oBusy, oPacket, oOverrun
  );

  modport slave (
    input  iByte, iByteValid,
    output oX_cell, oY_cell, oLeft, oRight,
    output oBusy, oPacket, oOverrun
  );
endinterface

// File: rtl/mouse_cell_tracker.sv
// PS/2 mouse packet assembler and cell-granular cursor tracker.
// MOUSE_CELL_TRACKER_TIMEOUT_EN enables the inter-byte resync timeout.
module mouse_cell_tracker #(
  parameter int SCREEN_WIDTH   = 640,
  parameter int SCREEN_HEIGHT  = 480,
  parameter int CELL_DIMENSION = 5,
  parameter int UPPER_BITS     = $clog2(
    ((SCREEN_WIDTH > SCREEN_HEIGHT) ? SCREEN_WIDTH : SCREEN_HEIGHT)
    / CELL_DIMENSION),
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                 iClk,
  input logic                 iResetn,
  mouse_cell_tracker_if.slave bus
);

  localparam int SW = $clog2(CELL_DIMENSION);
  localparam logic [SW-1:0] SUB_LAST = SW'(CELL_DIMENSION - 1);
  localparam logic [UPPER_BITS-1:0] XC_MAX =
    UPPER_BITS'((SCREEN_WIDTH - 1) / CELL_DIMENSION);
  localparam logic [SW-1:0] XS_MAX =
    SW'((SCREEN_WIDTH - 1) % CELL_DIMENSION);
  localparam logic [UPPER_BITS-1:0] YC_MAX =
    UPPER_BITS'((SCREEN_HEIGHT - 1) / CELL_DIMENSION);
  localparam logic [SW-1:0] YS_MAX =
    SW'((SCREEN_HEIGHT - 1) % CELL_DIMENSION);

  typedef enum logic [1:0] {B0, B1, B2} asm_t;
  typedef enum logic {IDLE, UPDATE} eng_t;

  asm_t asm_q, asm_d;
  eng_t eng_q, eng_d;

  logic [7:0]            hdr_q, dx_q;
  logic [8:0]            rem_x, rem_y, mag_x, mag_y;
  logic [8:0]            dx9, dy9;
  logic                  x_neg, y_dec;
  logic [UPPER_BITS-1:0] x_cell, y_cell;
  logic [SW-1:0]         x_sub, y_sub;
  logic                  left_q, right_q, pkt_q, ovr_q;
  logic                  pkt_done, accept, drop, upd, done;
  logic                  mv_x, mv_y, tmo;

  assign pkt_done = bus.iByteValid && (asm_q == B2);
  assign upd      = (eng_q == UPDATE);
  assign accept   = pkt_done && !upd;
  assign drop     = pkt_done && upd;
  assign done     = (rem_x == '0) && (rem_y == '0);

  // dy arrives on the completing cycle, so it is taken straight off the bus
  assign dx9   = {hdr_q[4], dx_q};
  assign dy9   = {hdr_q[5], bus.iByte};
  assign mag_x = hdr_q[6] ? 9'd0 : (hdr_q[4] ? -dx9 : dx9);
  assign mag_y = hdr_q[7] ? 9'd0 : (hdr_q[5] ? -dy9 : dy9);

  assign mv_x = upd && (rem_x != '0) && (x_neg
    ? !(x_cell == '0 && x_sub == '0)
    : !(x_cell == XC_MAX && x_sub == XS_MAX));
  assign mv_y = upd && (rem_y != '0) && (y_dec
    ? !(y_cell == '0 && y_sub == '0)
    : !(y_cell == YC_MAX && y_sub == YS_MAX));

`ifdef MOUSE_CELL_TRACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] gap_q;

  assign tmo = !bus.iByteValid && (asm_q != B0) &&
               (gap_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iClk) begin
    if (!iResetn || bus.iByteValid || asm_q == B0 || tmo)
      gap_q <= '0;
    else
      gap_q <= gap_q + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    asm_d = asm_q;
    if (bus.iByteValid) begin
      unique case (asm_q)
        B0:      asm_d = bus.iByte[3] ? B1 : B0;
        B1:      asm_d = B2;
        B2:      asm_d = B0;
        default: asm_d = B0;
      endcase
    end else if (tmo) begin
      asm_d = B0;
    end
  end

  always_comb begin
    eng_d = eng_q;
    unique case (eng_q)
      IDLE:    if (accept) eng_d = UPDATE;
      UPDATE:  if (done) eng_d = IDLE;
      default: eng_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iResetn) begin
      asm_q <= B0;
      eng_q <= IDLE;
    end else begin
      asm_q <= asm_d;
      eng_q <= eng_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iResetn) begin
      hdr_q   <= '0;
      dx_q    <= '0;
      rem_x   <= '0;
      rem_y   <= '0;
      x_neg   <= 1'b0;
      y_dec   <= 1'b0;
      x_cell  <= '0;
      x_sub   <= '0;
      y_cell  <= '0;
      y_sub   <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      pkt_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pkt_q <= upd && done;
      ovr_q <= drop;
      if (bus.iByteValid && asm_q == B0 && bus.iByte[3])
        hdr_q <= bus.iByte;
      if (bus.iByteValid && asm_q == B1)
        dx_q <= bus.iByte;
      if (accept) begin
        left_q  <= hdr_q[0];
        right_q <= hdr_q[1];
        rem_x   <= mag_x;
        rem_y   <= mag_y;
        x_neg   <= hdr_q[4];
        y_dec   <= !hdr_q[5];
      end
      // clamped steps still burn the remainder
      if (upd && rem_x != '0) rem_x <= rem_x - 1'b1;
      if (upd && rem_y != '0) rem_y <= rem_y - 1'b1;
      unique case (1'b1)
        mv_x && !x_neg: begin
          if (x_sub == SUB_LAST) begin
            x_sub  <= '0;
            x_cell <= x_cell + 1'b1;
          end else x_sub <= x_sub + 1'b1;
        end
        mv_x && x_neg: begin
          if (x_sub == '0) begin
            x_sub  <= SUB_LAST;
            x_cell <= x_cell - 1'b1;
          end else x_sub <= x_sub - 1'b1;
        end
        default: ;
      endcase
      unique case (1'b1)
        mv_y && !y_dec: begin
          if (y_sub == SUB_LAST) begin
            y_sub  <= '0;
            y_cell <= y_cell + 1'b1;
          end else y_sub <= y_sub + 1'b1;
        end
        mv_y && y_dec: begin
          if (y_sub == '0) begin
            y_sub  <= SUB_LAST;
            y_cell <= y_cell - 1'b1;
          end else y_sub <= y_sub - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.oX_cell  = x_cell;
  assign bus.oY_cell  = y_cell;
  assign bus.oLeft    = left_q;
  assign bus.oRight   = right_q;
  assign bus.oBusy    = upd;
  assign bus.oPacket  = pkt_q;
  assign bus.oOverrun = ovr_q;

endmodule

// File: tb/tb_mouse_cell_tracker.sv
// Randomized and directed bench for mouse_cell_tracker.
// Reference model works in whole pixels against a per-cycle timeline.
module tb_mouse_cell_tracker;

  localparam int W    = 640;
  localparam int H    = 480;
  localparam int CD   = 5;
  localparam int UB   = 7;
  localparam int TMO  = 50000;
`ifdef MOUSE_CELL_TRACKER_TIMEOUT_EN
  localparam int GAP  = TMO;
`else
  localparam int GAP  = 100;
`endif

  logic iClk;
  logic iResetn;
  int   n_cmp;
  int   n_err;

  mouse_cell_tracker_if #(.UPPER_BITS(UB)) bus ();

  mouse_cell_tracker #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .CELL_DIMENSION(CD),
    .UPPER_BITS(UB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .iClk(iClk), .iResetn(iResetn), .bus(bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d want %0d", tag, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_nb, m_k, m_len;
  int         m_x0, m_y0, m_dx, m_dy;
  logic [7:0] m_hdr, m_bx;
  bit         m_busy, m_left, m_right, m_pkt, m_ovr, m_started;
`ifdef MOUSE_CELL_TRACKER_TIMEOUT_EN
  int         m_gap;
`endif

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int delta(input logic s, input logic o,
                               input logic [7:0] b);
    if (o) return 0;
    return s ? int'(b) - 256 : int'(b);
  endfunction

  function automatic int cur_pix(input int p0, input int d,
                                 input int hi);
    int n;
    if (!m_busy) return p0;
    n = (m_k < absi(d)) ? m_k : absi(d);
    return clampi(p0 + ((d < 0) ? -n : n), hi);
  endfunction

  always @(posedge iClk) begin : mdl
    bit         was_busy, done;
    logic [7:0] b;
    if (!iResetn) begin
      m_nb = 0; m_busy = 0; m_k = 0; m_len = 0;
      m_x0 = 0; m_y0 = 0; m_dx = 0; m_dy = 0;
      m_left = 0; m_right = 0; m_pkt = 0; m_ovr = 0;
`ifdef MOUSE_CELL_TRACKER_TIMEOUT_EN
      m_gap = 0;
`endif
    end else begin
      m_pkt = 0; m_ovr = 0; done = 0;
      was_busy = m_busy;
      b = bus.iByte;
      if (bus.iByteValid) begin
`ifdef MOUSE_CELL_TRACKER_TIMEOUT_EN
        m_gap = 0;
`endif
        if (m_nb == 0) begin
          if (b[3]) begin m_hdr = b; m_nb = 1; end
        end else if (m_nb == 1) begin
          m_bx = b; m_nb = 2;
        end else begin
          m_nb = 0; done = 1;
        end
      end else if (m_nb != 0) begin
`ifdef MOUSE_CELL_TRACKER_TIMEOUT_EN
        m_gap++;
        if (m_gap == TMO) begin m_nb = 0; m_gap = 0; end
`endif
      end
      if (m_busy) begin
        m_k++;
        if (m_k == m_len) begin
          m_x0 = clampi(m_x0 + m_dx, W - 1);
          m_y0 = clampi(m_y0 + m_dy, H - 1);
          m_busy = 0; m_pkt = 1;
        end
      end
      if (done) begin
        if (was_busy) m_ovr = 1;
        else begin
          m_left  = m_hdr[0];
          m_right = m_hdr[1];
          m_dx    = delta(m_hdr[4], m_hdr[6], m_bx);
          m_dy    = -delta(m_hdr[5], m_hdr[7], b);
          m_len   = ((absi(m_dx) > absi(m_dy)) ? absi(m_dx)
                                               : absi(m_dy)) + 1;
          m_k = 0; m_busy = 1;
        end
      end
    end
    m_started = 1;
  end

  always @(negedge iClk) begin
    if (m_started) begin
      chk("x_cell", 32'(bus.oX_cell), cur_pix(m_x0, m_dx, W - 1) / CD);
      chk("y_cell", 32'(bus.oY_cell), cur_pix(m_y0, m_dy, H - 1) / CD);
      chk("left", 32'(bus.oLeft), 32'(m_left));
      chk("right", 32'(bus.oRight), 32'(m_right));
      chk("busy", 32'(bus.oBusy), 32'(m_busy));
      chk("packet", 32'(bus.oPacket), 32'(m_pkt));
      chk("overrun", 32'(bus.oOverrun), 32'(m_ovr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge iClk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    bus.iByte = b;
    bus.iByteValid = 1'b1;
    @(posedge iClk); #1;
    bus.iByteValid = 1'b0;
  endtask

  task automatic pkt(input logic [7:0] h, input logic [7:0] x,
                     input logic [7:0] y);
    send(h); send(x); send(y);
  endtask

  task automatic do_reset();
    iResetn = 1'b0;
    idle(3);
    iResetn = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.oBusy && n < 5000) begin idle(1); n++; end
    chk("idle_bound", 32'(bus.oBusy), 0);
    idle(2);
  endtask

  initial begin
    int n, np, no;
    n_cmp = 0; n_err = 0; m_started = 0;
    iResetn = 1'b0;
    bus.iByte = '0;
    bus.iByteValid = 1'b0;
    @(posedge iClk); #1;
    do_reset();
    chk("rst_x", 32'(bus.oX_cell), 0);
    chk("rst_busy", 32'(bus.oBusy), 0);

    // +7 in X: busy 8 cycles, cell 1
    pkt(8'h08, 8'h07, 8'h00);
    n = 0;
    while (bus.oBusy && n < 1000) begin idle(1); n++; end
    chk("r020_busy_len", n, 8);
    chk("r020_packet", 32'(bus.oPacket), 1);
    chk("r020_x", 32'(bus.oX_cell), 1);
    chk("r020_left", 32'(bus.oLeft), 0);

    // clamp at origin, Y moves down one pixel
    do_reset();
    pkt(8'h38, 8'hFF, 8'hFF);
    np = 0;
    for (int i = 0; i < 20; i++) begin
      np += int'(bus.oPacket);
      idle(1);
    end
    chk("r021_pkts", np, 1);
    chk("r021_x", 32'(bus.oX_cell), 0);
    chk("r021_y", 32'(bus.oY_cell), 0);
    pkt(8'h28, 8'h00, 8'hFC);
    wait_idle();
    chk("r021_y_sub", 32'(bus.oY_cell), 1);

    // right-edge clamp
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pkt(8'h08, 8'hFF, 8'h00);
      wait_idle();
    end
    chk("r022_x", 32'(bus.oX_cell), 127);
    pkt(8'h08, 8'h05, 8'h00);
    wait_idle();
    chk("r022_x_clamp", 32'(bus.oX_cell), 127);

    // resync on bad header
    do_reset();
    send(8'h01);
    pkt(8'h09, 8'h00, 8'h00);
    wait_idle();
    chk("r023_left", 32'(bus.oLeft), 1);

    // packet during busy is dropped
    do_reset();
    pkt(8'h08, 8'h20, 8'h00);
    pkt(8'h0B, 8'h10, 8'h00);
    chk("r024_ovr", 32'(bus.oOverrun), 1);
    no = 0;
    while (bus.oBusy && no < 1000) begin
      idle(1); no++;
      chk("r024_ovr_once", 32'(bus.oOverrun), 0);
    end
    wait_idle();
    chk("r024_x", 32'(bus.oX_cell), 6);
    chk("r024_left", 32'(bus.oLeft), 0);

    // partial packet across a long gap
    do_reset();
    send(8'h08);
    idle(GAP);
    pkt(8'h09, 8'h00, 8'h00);
    wait_idle();
`ifdef MOUSE_CELL_TRACKER_TIMEOUT_EN
    chk("r025_left", 32'(bus.oLeft), 1);
    chk("r025_x", 32'(bus.oX_cell), 0);
`else
    chk("r025_left", 32'(bus.oLeft), 0);
    chk("r025_x", 32'(bus.oX_cell), 1);
`endif

    // reset mid-update abandons work
    do_reset();
    pkt(8'h08, 8'h64, 8'h00);
    idle(10);
    iResetn = 1'b0;
    idle(2);
    iResetn = 1'b1;
    np = 0;
    for (int i = 0; i < 150; i++) begin
      np += int'(bus.oPacket);
      idle(1);
    end
    chk("r018_no_pkt", np, 0);
    chk("r018_x", 32'(bus.oX_cell), 0);

    // random byte stream
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(2) == 0) send(8'($urandom));
      else idle(1);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
